simon_control: RTL and testbench
================================

SIMON_CONTROL -- requirements
Module: simon_control

Interface
REQ-001 Parameters: none; state encoding constants come from the shared package.
REQ-002 clk  input  1  single system clock (the uclk button), all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; forces state INPUT immediately.
REQ-004 legal  input  1  datapath: current pattern is legal for the latched level.
REQ-005 correct_pat  input  1  datapath: pattern equals mem[i].
REQ-006 i_lt_last  input  1  datapath: index i < last.
REQ-007 arr_full  input  1  datapath: last == 63.
REQ-008 mem_ld  output  1  store pattern at mem[last] on this edge.
REQ-009 i_clr  output  1  clear i to 0 on this edge.
REQ-010 i_inc  output  1  increment i on this edge.
REQ-011 last_inc  output  1  increment last on this edge.
REQ-012 s_led_eq_pat  output  1  1: LEDs show switches; 0: LEDs show mem[i].
REQ-013 mode_leds  output  3  state indicator: INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111.

Function
REQ-014 Four-state FSM {INPUT, PLAYBACK, REPEAT, DONE}, one state register, next-state and outputs combinational (strobes Mealy on datapath flags).
REQ-015 Strobes (mem_ld, i_clr, i_inc, last_inc) default 0; at most the combinations listed below asserted in any cycle.
REQ-016 INPUT: s_led_eq_pat=1; legal=1 -> mem_ld=1, i_clr=1, next PLAYBACK; legal=0 -> no strobe, stay.
REQ-017 PLAYBACK: s_led_eq_pat=0; i_lt_last=1 -> i_inc=1, stay; i_lt_last=0 -> i_clr=1, next REPEAT.
REQ-018 REPEAT: s_led_eq_pat=1; correct_pat=0 -> i_clr=1, next DONE (takes priority over all other REPEAT conditions).
REQ-019 REPEAT, correct_pat=1, i_lt_last=1 -> i_inc=1, stay.
REQ-020 REPEAT, correct_pat=1, i_lt_last=0, arr_full=0 -> last_inc=1, next INPUT.
REQ-021 REPEAT, correct_pat=1, i_lt_last=0, arr_full=1 -> i_clr=1, next DONE (win: sequence full).
REQ-022 DONE: s_led_eq_pat=0; i_lt_last=1 -> i_inc=1; i_lt_last=0 -> i_clr=1 (playback wraps to index 0); DONE exits only via rst.
REQ-023 Latency: strobes take effect on the same edge that performs the transition; one state transition per clk edge.
REQ-024 Inputs are assumed stable across the edge; no internal synchronisation or debouncing.
REQ-025 Unreachable state encodings SHALL next-state to INPUT with all strobes 0.

Reset
REQ-026 rst=1 -> state INPUT asynchronously; while rst=1 all strobes forced 0, s_led_eq_pat=1, mode_leds=001.
REQ-027 rst asserted mid-PLAYBACK/REPEAT/DONE abandons the game; first edge after release evaluates INPUT rules.
REQ-028 Datapath reset (level latch, last=0) is driven by the same rst net; the block issues no extra clear.

Structure
REQ-029 Shared package holds state encoding constants (2-bit) and mode_leds codes per state.
REQ-030 No sub-module; top-level instantiates simon_control alongside the datapath, connected port-for-port by name.

Verification
REQ-031 rst pulse, legal=0, 3 edges -> state INPUT throughout, no strobes, mode_leds=001.
REQ-032 INPUT, legal=1, edge -> mem_ld=1,i_clr=1 that cycle; then PLAYBACK, mode_leds=010, s_led_eq_pat=0.
REQ-033 PLAYBACK with i_lt_last=1,1,0 across 3 edges -> i_inc,i_inc,i_clr; then REPEAT, mode_leds=100.
REQ-034 REPEAT correct_pat=1,i_lt_last=0,arr_full=0 -> last_inc=1, next INPUT; same with arr_full=1 -> i_clr=1, next DONE.
REQ-035 REPEAT correct_pat=0,i_lt_last=1 -> i_clr=1 only (no i_inc), next DONE, mode_leds=111; DONE then cycles i_inc/i_clr per i_lt_last.
REQ-036 rst asserted between edges while in DONE -> mode_leds=001 before next edge, strobes 0.

Source files
------------

// File: rtl/simon_control_pkg.sv
// Shared state encoding and mode indicator codes for the Simon game controller.
package simon_control_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'b00,
        ST_PLAYBACK = 2'b01,
        ST_REPEAT   = 2'b10,
        ST_DONE     = 2'b11
    } state_e;

    localparam logic [2:0] MODE_INPUT    = 3'b001;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b100;
    localparam logic [2:0] MODE_DONE     = 3'b111;

    function automatic logic [2:0] mode_of(input state_e s);
        logic [2:0] m;
        m = MODE_INPUT;
        case (s)
            ST_INPUT:    m = MODE_INPUT;
            ST_PLAYBACK: m = MODE_PLAYBACK;
            ST_REPEAT:   m = MODE_REPEAT;
            ST_DONE:     m = MODE_DONE;
            default:     m = MODE_INPUT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simon_control_if.sv
// Controller <-> datapath bundle: status flags toward the FSM, strobes and display selects back.
interface simon_control_if;
    logic       legal;
    logic       correct_pat;
    logic       i_lt_last;
    logic       arr_full;
    logic       mem_ld;
    logic       i_clr;
    logic       i_inc;
    logic       last_inc;
    logic       s_led_eq_pat;
    logic [2:0] mode_leds;

    modport master (
        input  legal, correct_pat, i_lt_last, arr_full,
        output mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, mode_leds
    );

    modport slave (
        output legal, correct_pat, i_lt_last, arr_full,
        input  mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, mode_leds
    );
endinterface

// File: rtl/simon_control.sv
// Simon game FSM: Mealy strobes to the datapath act on the same edge as the state change.
// No backpressure: flags are sampled every edge; rst forces INPUT and masks all strobes at once.
module simon_control
    import simon_control_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    simon_control_if.master  ctl
);

    state_e     state_q;
    state_e     state_d;
    logic       mem_ld;
    logic       i_clr;
    logic       i_inc;
    logic       last_inc;
    logic       s_led_eq_pat;
    logic [2:0] mode_leds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INPUT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_ld       = 1'b0;
        i_clr        = 1'b0;
        i_inc        = 1'b0;
        last_inc     = 1'b0;
        s_led_eq_pat = 1'b1;
        mode_leds    = mode_of(state_q);

        case (state_q)
            ST_INPUT: begin
                if (ctl.legal) begin
                    mem_ld  = 1'b1;
                    i_clr   = 1'b1;
                    state_d = ST_PLAYBACK;
                end
            end
            ST_PLAYBACK: begin
                s_led_eq_pat = 1'b0;
                if (ctl.i_lt_last) begin
                    i_inc = 1'b1;
                end else begin
                    i_clr   = 1'b1;
                    state_d = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                // A wrong entry ends the game regardless of position or fill level.
                if (!ctl.correct_pat) begin
                    i_clr   = 1'b1;
                    state_d = ST_DONE;
                end else if (ctl.i_lt_last) begin
                    i_inc = 1'b1;
                end else if (!ctl.arr_full) begin
                    last_inc = 1'b1;
                    state_d  = ST_INPUT;
                end else begin
                    i_clr   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                s_led_eq_pat = 1'b0;
                if (ctl.i_lt_last) begin
                    i_inc = 1'b1;
                end else begin
                    i_clr = 1'b1;
                end
            end
            default: begin
                state_d   = ST_INPUT;
                mode_leds = MODE_INPUT;
            end
        endcase

        // Reset is asynchronous, so the outputs must not wait for state_q to settle.
        if (rst) begin
            state_d      = ST_INPUT;
            mem_ld       = 1'b0;
            i_clr        = 1'b0;
            i_inc        = 1'b0;
            last_inc     = 1'b0;
            s_led_eq_pat = 1'b1;
            mode_leds    = MODE_INPUT;
        end
    end

    assign ctl.mem_ld       = mem_ld;
    assign ctl.i_clr        = i_clr;
    assign ctl.i_inc        = i_inc;
    assign ctl.last_inc     = last_inc;
    assign ctl.s_led_eq_pat = s_led_eq_pat;
    assign ctl.mode_leds    = mode_leds;

endmodule

// File: tb/tb_simon_control.sv
// Randomized bench for simon_control against a rule-table model of the game phases.
module tb_simon_control;

    localparam int P_IN = 0;
    localparam int P_PB = 1;
    localparam int P_RP = 2;
    localparam int P_DN = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   phase;
    int   exp_next;
    logic [7:0] exp_out;
    logic [7:0] got;
    logic [2:0] leds_tab [4];

    simon_control_if bus ();

    simon_control dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, mode_leds[2:0]}
    function automatic logic [7:0] observe();
        return {bus.mem_ld, bus.i_clr, bus.i_inc, bus.last_inc,
                bus.s_led_eq_pat, bus.mode_leds};
    endfunction

    function automatic void predict(input int ph, input logic r, l, c, il, af,
                                    output logic [7:0] o, output int nph);
        logic [3:0] strobes;   // {mem_ld, i_clr, i_inc, last_inc}
        logic       shows_sw;
        strobes  = 4'b0000;
        nph      = ph;
        shows_sw = (ph == P_IN) || (ph == P_RP);
        if (ph == P_IN && l) begin
            strobes = 4'b1100; nph = P_PB;
        end else if (ph == P_PB) begin
            if (il) strobes = 4'b0010;
            else begin strobes = 4'b0100; nph = P_RP; end
        end else if (ph == P_RP) begin
            if (!c)      begin strobes = 4'b0100; nph = P_DN; end
            else if (il)       strobes = 4'b0010;
            else if (!af) begin strobes = 4'b0001; nph = P_IN; end
            else         begin strobes = 4'b0100; nph = P_DN; end
        end else if (ph == P_DN) begin
            strobes = il ? 4'b0010 : 4'b0100;
        end
        o = {strobes, shows_sw, leds_tab[ph]};
        if (r) begin
            o   = {4'b0000, 1'b1, leds_tab[P_IN]};
            nph = P_IN;
        end
    endfunction

    task automatic drive(input logic r, l, c, il, af);
        @(negedge clk);
        rst             = r;
        bus.legal       = l;
        bus.correct_pat = c;
        bus.i_lt_last   = il;
        bus.arr_full    = af;
        if (r) phase = P_IN;
        #1;
        predict(phase, r, l, c, il, af, exp_out, exp_next);
    endtask

    task automatic tick();
        @(posedge clk);
        phase = rst ? P_IN : exp_next;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic go_repeat();
        drive(1'b0, 1'b1, rb(), rb(), rb()); tick();
        drive(1'b0, rb(), rb(), 1'b0, rb()); tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, rb(), rb(), rb(), rb());
            got = observe();
            total++;
            if (got !== 8'b0000_1_001) begin
                bad++; $display("FAIL reset_hold[%0d]: got %b want %b", k, got, 8'b0000_1_001);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, rb(), rb(), rb());
            got = observe();
            total++;
            if (got !== exp_out) begin
                bad++; $display("FAIL input_idle[%0d]: got %b want %b", k, got, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_playback();
        logic [2:0] il_seq;
        il_seq = 3'b011;
        do_reset();
        drive(1'b0, 1'b1, rb(), rb(), rb());
        got = observe();
        total++;
        if (got !== exp_out) begin
            bad++; $display("FAIL input_legal: got %b want %b", got, exp_out);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, rb(), rb(), il_seq[k], rb());
            got = observe();
            total++;
            if (got !== exp_out) begin
                bad++; $display("FAIL playback[%0d]: got %b want %b", k, got, exp_out);
            end
            tick();
        end
        drive(1'b0, rb(), 1'b1, 1'b1, rb());
        total++;
        if (bus.mode_leds !== 3'b100) begin
            bad++; $display("FAIL repeat_mode: got %b want %b", bus.mode_leds, 3'b100);
        end
        tick();
    endtask

    task automatic test_grow_and_win();
        do_reset();
        go_repeat();
        drive(1'b0, rb(), 1'b1, 1'b0, 1'b0);
        got = observe();
        total++;
        if (got !== exp_out) begin
            bad++; $display("FAIL repeat_grow: got %b want %b", got, exp_out);
        end
        tick();
        drive(1'b0, 1'b0, rb(), rb(), rb());
        total++;
        if (bus.mode_leds !== 3'b001) begin
            bad++; $display("FAIL back_to_input: got %b want %b", bus.mode_leds, 3'b001);
        end
        tick();
        go_repeat();
        drive(1'b0, rb(), 1'b1, 1'b0, 1'b1);
        got = observe();
        total++;
        if (got !== exp_out) begin
            bad++; $display("FAIL repeat_full: got %b want %b", got, exp_out);
        end
        tick();
        drive(1'b0, rb(), rb(), 1'b1, rb());
        got = observe();
        total++;
        if (got !== exp_out) begin
            bad++; $display("FAIL win_done: got %b want %b", got, exp_out);
        end
        tick();
    endtask

    task automatic test_fail_and_done();
        do_reset();
        go_repeat();
        drive(1'b0, rb(), 1'b0, 1'b1, rb());
        got = observe();
        total++;
        if (got !== 8'b0100_1_100) begin
            bad++; $display("FAIL repeat_wrong: got %b want %b", got, 8'b0100_1_100);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, rb(), rb(), rb(), rb());
            got = observe();
            total++;
            if (got !== exp_out) begin
                bad++; $display("FAIL done_cycle[%0d]: got %b want %b", k, got, exp_out);
            end
            tick();
        end
        drive(1'b1, rb(), rb(), rb(), rb());
        got = observe();
        total++;
        if (got !== 8'b0000_1_001) begin
            bad++; $display("FAIL done_midreset: got %b want %b", got, 8'b0000_1_001);
        end
        tick();
        drive(1'b0, 1'b0, rb(), rb(), rb());
        got = observe();
        total++;
        if (got !== exp_out) begin
            bad++; $display("FAIL after_reset: got %b want %b", got, exp_out);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(24) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(5) != 0), rb(), ($urandom_range(3) == 0));
            got = observe();
            total++;
            if (got !== exp_out) begin
                bad++; $display("FAIL random[%0d]: got %b want %b", k, got, exp_out);
            end
            tick();
        end
    endtask

    initial begin
        leds_tab[P_IN] = 3'b001;
        leds_tab[P_PB] = 3'b010;
        leds_tab[P_RP] = 3'b100;
        leds_tab[P_DN] = 3'b111;
        total           = 0;
        bad             = 0;
        phase           = P_IN;
        exp_next        = P_IN;
        exp_out         = 8'h00;
        rst             = 1'b1;
        bus.legal       = 1'b0;
        bus.correct_pat = 1'b0;
        bus.i_lt_last   = 1'b0;
        bus.arr_full    = 1'b0;
        test_reset();
        test_playback();
        test_grow_and_win();
        test_fail_and_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
